fetch_ctrl: RTL and testbench

Instruction-fetch controller that owns the program counter and sequences instruction-memory reads. It issues one fetch request at a time, waits for the memory acknowledge, and presents the fetched word to decode with a valid/ready handshake. It applies control-flow redirects (branch/jump target from the ALU) at the correct point in the fetch sequence, including while a request is in flight. It sits between the PC-select logic and the instruction memory port.

---
 rtl/fetch_ctrl.sv | 89 ++++++++
 tb/tb_fetch_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: owns the PC, issues one imem fetch at a time and hands words to decode via valid/ready.
module fetch_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pc_4,
  output logic        misalign_err
);
  typedef enum logic [1:0] {IDLE, FETCH, VALID, DISCARD} state_t;
  state_t      state, state_n;
  logic [31:0] pc, pc_n, pend_tgt, pend_tgt_n;
  logic        pend, pend_n, load;
  logic        aligned;
  assign aligned    = redirect && redirect_target[1:0] == 2'b00;
  assign imem_req   = state == FETCH || state == DISCARD;
  assign imem_addr  = pc;
  assign inst_valid = state == VALID;
  assign inst_pc_4  = inst_pc + 32'd4;
  always_comb begin
    state_n    = state;
    pc_n       = pc;
    pend_n     = pend;
    pend_tgt_n = pend_tgt;
    load       = 1'b0;
    case (state)
      IDLE: begin
        state_n = FETCH;
        pc_n    = aligned ? redirect_target : pc;
      end
      FETCH: begin
        if (imem_ack) begin
          pc_n    = aligned ? redirect_target : pc;
          load    = !aligned;
          state_n = aligned ? FETCH : VALID;
        end else if (aligned) begin
          pend_n     = 1'b1;
          pend_tgt_n = redirect_target;
          state_n    = DISCARD;
        end
      end
      DISCARD: begin
        // the outstanding address stays on the bus; only the latest target is kept
        pend_tgt_n = aligned ? redirect_target : pend_tgt;
        if (imem_ack) begin
          pc_n    = pend_tgt_n;
          pend_n  = 1'b0;
          state_n = FETCH;
        end
      end
      VALID: begin
        pc_n    = aligned ? redirect_target : inst_ready ? pc + 32'd4 : pc;
        state_n = aligned || inst_ready ? FETCH : VALID;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      pc           <= RESET_VECTOR;
      pend         <= 1'b0;
      pend_tgt     <= RESET_VECTOR;
      inst         <= 32'd0;
      inst_pc      <= 32'd0;
      misalign_err <= 1'b0;
    end else begin
      state        <= state_n;
      pc           <= pc_n;
      pend         <= pend_n;
      pend_tgt     <= pend_tgt_n;
      misalign_err <= redirect && redirect_target[1:0] != 2'b00;
      if (load) begin
        inst    <= imem_rdata;
        inst_pc <= pc;
      end
    end
  end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: scoreboard bench for fetch_ctrl; acked words are queued and matched at decode handoff.
module tb_fetch_ctrl;
  logic        clk = 1'b0, rst = 1'b0;
  logic        redirect = 1'b0, imem_ack = 1'b0, inst_ready = 1'b0;
  logic [31:0] redirect_target = 32'd0, imem_rdata = 32'd0;
  logic        imem_req, inst_valid, misalign_err;
  logic [31:0] imem_addr, inst, inst_pc, inst_pc_4;
  int          n_vec = 0, n_err = 0;
  typedef struct {logic [31:0] pc; logic [31:0] w;} ent_t;
  ent_t sb[$];
  fetch_ctrl dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_target(redirect_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .inst_pc_4(inst_pc_4), .misalign_err(misalign_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic do_fetch(input int lat, input int hold, input logic [31:0] a);
    ent_t e;
    chk("req", imem_req, 1);
    chk("addr", imem_addr, a);
    for (int i = 0; i < lat; i++) begin
      cyc();
      chk("addr_hold", imem_addr, a);
      chk("wait_no_valid", inst_valid, 0);
    end
    imem_ack = 1'b1;
    imem_rdata = ~a;
    sb.push_back('{a, ~a});
    cyc();
    imem_ack = 1'b0;
    imem_rdata = 32'd0;
    chk("valid", inst_valid, 1);
    for (int i = 0; i < hold; i++) begin
      cyc();
      chk("stall_valid", inst_valid, 1);
      chk("stall_noreq", imem_req, 0);
      chk("stall_pc", inst_pc, a);
      chk("stall_inst", inst, ~a);
    end
    inst_ready = 1'b1;
    if (sb.size() == 0) chk("sb_empty", 1, 0);
    else begin
      e = sb.pop_front();
      chk("inst", inst, e.w);
      chk("inst_pc", inst_pc, e.pc);
      chk("inst_pc_4", inst_pc_4, e.pc + 32'd4);
    end
    cyc();
    inst_ready = 1'b0;
    chk("valid_drop", inst_valid, 0);
  endtask
  initial begin
    #2 rst = 1'b1;
    #1;
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_valid", inst_valid, 0);
    chk("rst_pc4", inst_pc_4, 4);
    chk("rst_mis", misalign_err, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    chk("idle_req", imem_req, 0);
    cyc();
    do_fetch(0, 0, 32'h0);
    do_fetch(0, 0, 32'h4);
    do_fetch(3, 0, 32'h8);
    do_fetch(0, 5, 32'hC);
    // redirect while an instruction is waiting for decode, with ready also high
    chk("f10_addr", imem_addr, 32'h10);
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_0010;
    cyc();
    imem_ack = 1'b0;
    chk("v10_valid", inst_valid, 1);
    redirect = 1'b1;
    redirect_target = 32'h100;
    inst_ready = 1'b1;
    cyc();
    redirect = 1'b0;
    inst_ready = 1'b0;
    chk("rv_valid", inst_valid, 0);
    chk("rv_addr", imem_addr, 32'h100);
    redirect = 1'b1;
    redirect_target = 32'h200;
    cyc();
    chk("disc_addr", imem_addr, 32'h100);
    chk("disc_req", imem_req, 1);
    redirect_target = 32'h300;
    cyc();
    redirect = 1'b0;
    cyc();
    chk("disc_addr2", imem_addr, 32'h100);
    imem_ack = 1'b1;
    imem_rdata = 32'hBAD0_0100;
    cyc();
    imem_ack = 1'b0;
    chk("disc_novalid", inst_valid, 0);
    do_fetch(0, 0, 32'h300);
    chk("f304", imem_addr, 32'h304);
    imem_ack = 1'b1;
    redirect = 1'b1;
    redirect_target = 32'h400;
    cyc();
    imem_ack = 1'b0;
    redirect = 1'b0;
    chk("ackred_valid", inst_valid, 0);
    chk("ackred_addr", imem_addr, 32'h400);
    redirect = 1'b1;
    redirect_target = 32'h102;
    cyc();
    redirect = 1'b0;
    chk("mis_pulse", misalign_err, 1);
    chk("mis_addr", imem_addr, 32'h400);
    cyc();
    chk("mis_clear", misalign_err, 0);
    do_fetch(0, 0, 32'h400);
    chk("f404", imem_addr, 32'h404);
    imem_ack = 1'b1;
    redirect = 1'b1;
    redirect_target = 32'h10;
    cyc();
    imem_ack = 1'b0;
    redirect = 1'b0;
    chk("f10b", imem_addr, 32'h10);
    cyc();
    cyc();
    #2 rst = 1'b1;
    #1;
    chk("mrst_req", imem_req, 0);
    chk("mrst_addr", imem_addr, 0);
    chk("mrst_valid", inst_valid, 0);
    chk("mrst_inst", inst, 0);
    chk("mrst_pc", inst_pc, 0);
    chk("mrst_pc4", inst_pc_4, 4);
    @(posedge clk);
    #1 rst = 1'b0;
    chk("mrst_idle", imem_req, 0);
    cyc();
    chk("refetch", imem_addr, 32'h0);
    imem_ack = 1'b1;
    redirect = 1'b1;
    redirect_target = 32'hFFFF_FFFC;
    cyc();
    imem_ack = 1'b0;
    redirect = 1'b0;
    do_fetch(0, 0, 32'hFFFF_FFFC);
    chk("wrap_addr", imem_addr, 32'h0);
    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
